// File: rtl/dport_resp_ram.sv
// Data-port responder: word RAM with byte strobes behind the core's mem_d_* port, fixed-latency in-order acks.
// Define DPORT_RESP_STALL_EN to add LFSR-driven pseudo-random backpressure on accept.
module dport_resp_ram #(
  parameter int          ADDR_W          = 12,
  parameter logic [31:0] BASE_ADDR       = 32'h80000000,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 3;

  logic [31:0]       mem_q [DEPTH];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [10:0]       tag_q  [LATENCY];
  logic [10:0]       tag_d  [LATENCY];
  logic [31:0]       data_q [LATENCY];
  logic [31:0]       data_d [LATENCY];
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;

  logic              req, take, ack, stall_ok;
  logic              is_cmo, is_wr, is_rd, in_range;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word, wr_word;
  logic              mem_wr_en;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              unused_ok;

`ifdef DPORT_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end

  assign stall_ok = lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif

  assign req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign mem_d_accept_o = rst & (outstanding_q < CNT_W'(MAX_OUTSTANDING)) & stall_ok;
  assign take = req & mem_d_accept_o;
  assign ack  = vld_q[LATENCY-1];

  // Maintenance ops win over rd/wr; a write with rd also set is still a write.
  assign is_cmo   = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
  assign is_wr    = !is_cmo && (mem_d_wr_i != 4'h0);
  assign is_rd    = !is_cmo && !is_wr && mem_d_rd_i;
  assign offset   = mem_d_addr_i - BASE_ADDR;
  assign in_range = (offset >> (ADDR_W + 2)) == 32'h0;
  assign idx      = offset[ADDR_W+1:2];
  assign rd_word  = mem_q[idx];
  assign unused_ok = ^{mem_d_cacheable_i, offset[1:0]};

  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_d_wr_i[b]) wr_word[8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
    end
    mem_wr_en = take && is_wr && in_range;
    resp_data = (take && is_rd && in_range) ? rd_word : 32'h0;
    resp_err  = take && !is_cmo && !in_range;
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_q[idx] <= wr_word;
  end

  always_comb begin
    vld_d[0]  = take;
    tag_d[0]  = take ? mem_d_req_tag_i : 11'h0;
    data_d[0] = resp_data;
    err_d[0]  = resp_err;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      tag_d[i]  = tag_q[i-1];
      data_d[i] = data_q[i-1];
      err_d[i]  = err_q[i-1];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (take && !ack)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!take && ack) outstanding_d = outstanding_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q         <= '0;
      err_q         <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i]  <= 11'h0;
        data_q[i] <= 32'h0;
      end
    end else begin
      vld_q         <= vld_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Idle pipeline slots carry zeros, so the outputs are already clean when ack is low.
  assign mem_d_ack_o      = ack;
  assign mem_d_resp_tag_o = tag_q[LATENCY-1];
  assign mem_d_data_rd_o  = data_q[LATENCY-1];
  assign mem_d_error_o    = err_q[LATENCY-1];

endmodule

// File: tb/tb_dport_resp_ram.sv
// Bench for dport_resp_ram: directed scenarios plus random traffic against a queue-based response model.
module tb_dport_resp_ram;

  localparam int          LAT   = 2;
  localparam int          MAXO  = 2;
  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam longint      BYTES = 4 * (longint'(1) << AW);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        rd;
  logic [3:0]  wr;
  logic        cacheable;
  logic [10:0] tag;
  logic        inv, wb, flush;
  logic [31:0] data_rd;
  logic        accept, ack, err;
  logic [10:0] resp_tag;

  typedef struct {
    int          due;
    logic [10:0] tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [int];
  bit          ack_seen [2048];
  logic [31:0] ack_data [2048];
  logic        ack_err  [2048];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_on = 0;
  bit          took_prev = 0;

  dport_resp_ram #(
    .ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_d_addr_i(addr), .mem_d_data_wr_i(wdata), .mem_d_rd_i(rd), .mem_d_wr_i(wr),
    .mem_d_cacheable_i(cacheable), .mem_d_req_tag_i(tag),
    .mem_d_invalidate_i(inv), .mem_d_writeback_i(wb), .mem_d_flush_i(flush),
    .mem_d_data_rd_o(data_rd), .mem_d_accept_o(accept), .mem_d_ack_o(ack),
    .mem_d_error_o(err), .mem_d_resp_tag_o(resp_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // Reference: a request taken now is answered exactly LAT cycles later, in take order.
  task automatic modelTake();
    exp_t        e;
    longint      a;
    int          widx;
    logic [31:0] w;
    e.due  = cyc + LAT;
    e.tag  = tag;
    e.data = 32'h0;
    e.err  = 1'b0;
    a      = longint'(addr);
    if (inv || wb || flush) begin
      e.err = 1'b0;
    end else if (a < longint'(BASE) || a >= longint'(BASE) + BYTES) begin
      e.err = 1'b1;
    end else begin
      widx = int'((a - longint'(BASE)) / 4);
      if (wr != 4'h0) begin
        w = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
        for (int b = 0; b < 4; b++) if (wr[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model_mem[widx] = w;
      end else begin
        e.data = model_mem.exists(widx) ? model_mem[widx] : 32'h0;
      end
    end
    exp_q.push_back(e);
  endtask

  // Per-cycle monitor: accept, ack contents/timing, idle outputs, then record any take.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      checkOutput("accept", {31'h0, accept}, {31'h0, (rst && exp_q.size() < MAXO)});
      if (ack) begin
        ack_seen[resp_tag] = 1'b1;
        ack_data[resp_tag] = data_rd;
        ack_err[resp_tag]  = err;
        if (exp_q.size() == 0) begin
          checkOutput("ack_unexpected", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ack_tag", {21'h0, resp_tag}, {21'h0, e.tag});
          checkOutput("ack_data", data_rd, e.data);
          checkOutput("ack_err", {31'h0, err}, {31'h0, e.err});
          checkOutput("ack_time", cyc, e.due);
        end
      end else begin
        checkOutput("idle_data", data_rd, 32'h0);
        checkOutput("idle_tag_err", {20'h0, err, resp_tag}, 32'h0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          checkOutput("ack_missing", 32'h0, 32'h1);
          void'(exp_q.pop_front());
        end
      end
      took_prev = 1'b0;
      if (!rst) begin
        exp_q.delete();
      end else if ((rd || wr != 4'h0 || inv || wb || flush) && accept) begin
        modelTake();
        took_prev = 1'b1;
      end
    end
  end

  task automatic driveIdle();
    rd = 1'b0; wr = 4'h0; inv = 1'b0; wb = 1'b0; flush = 1'b0;
    addr = 32'h0; wdata = 32'h0; tag = 11'h0; cacheable = 1'b0;
  endtask

  // Present one request and hold it until the edge that takes it.
  task automatic applyStimulus(input logic r, input logic [3:0] w, input logic [31:0] a,
                               input logic [31:0] d, input logic [10:0] t,
                               input logic i, input logic b, input logic f);
    int n;
    rd = r; wr = w; addr = a; wdata = d; tag = t; inv = i; wb = b; flush = f;
    cacheable = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!took_prev && n < 200);
    if (!took_prev) checkOutput("take_timeout", 32'h0, 32'h1);
    driveIdle();
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", exp_q.size(), 32'h0);
  endtask

  task automatic checkResp(input logic [10:0] t, input logic [31:0] d, input logic e);
    checkOutput("resp_seen", {31'h0, ack_seen[t]}, 32'h1);
    checkOutput("resp_data", ack_data[t], d);
    checkOutput("resp_err", {31'h0, ack_err[t]}, {31'h0, e});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          op;
    logic [31:0] a;
    logic [10:0] t;
    logic [3:0]  w;
    for (int i = 0; i < 2048; i++) begin
      ack_seen[i] = 1'b0;
      ack_data[i] = 32'h0;
      ack_err[i]  = 1'b0;
    end
    rst = 1'b0;
    driveIdle();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", {31'h0, ack}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_tag", {21'h0, resp_tag}, 32'h0);
    checkOutput("rst_data", data_rd, 32'h0);
    checkOutput("rst_accept", {31'h0, accept}, 32'h0);
    rst = 1'b1;
    mon_on = 1'b1;

    $display("[TB] full write then read");
    applyStimulus(0, 4'hF, 32'h80000010, 32'hDEADBEEF, 11'h005, 0, 0, 0);
    waitIdle();
    checkResp(11'h005, 32'h0, 1'b0);
    applyStimulus(1, 4'h0, 32'h80000010, 32'h0, 11'h006, 0, 0, 0);
    waitIdle();
    checkResp(11'h006, 32'hDEADBEEF, 1'b0);

    $display("[TB] byte strobe write, read on the very next cycle");
    applyStimulus(0, 4'b0010, 32'h80000010, 32'h0000AA00, 11'h007, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h80000010, 32'h0, 11'h008, 0, 0, 0);
    waitIdle();
    checkResp(11'h008, 32'hDEADAAEF, 1'b0);

    $display("[TB] back-to-back reads against outstanding limit");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 4'hF, 32'h80000100 + 32'(4*i), 32'hA5A50000 + 32'(i), 11'(16 + i), 0, 0, 0);
    waitIdle();
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 4'h0, 32'h80000100 + 32'(4*i), 32'h0, 11'(1 + i), 0, 0, 0);
    waitIdle();
    checkResp(11'h004, 32'hA5A50003, 1'b0);

    $display("[TB] range checks");
    applyStimulus(0, 4'hF, 32'h80000000, 32'h12345678, 11'h020, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h00001000, 32'h0, 11'h7FF, 0, 0, 0);
    applyStimulus(0, 4'hF, 32'h80010000, 32'hFFFFFFFF, 11'h021, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h80000000, 32'h0, 11'h022, 0, 0, 0);
    applyStimulus(0, 4'hF, 32'h80003FFC, 32'hCAFEF00D, 11'h023, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h80003FFC, 32'h0, 11'h024, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h80004000, 32'h0, 11'h025, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h7FFFFFFC, 32'h0, 11'h026, 0, 0, 0);
    waitIdle();
    checkResp(11'h7FF, 32'h0, 1'b1);
    checkResp(11'h021, 32'h0, 1'b1);
    checkResp(11'h022, 32'h12345678, 1'b0);
    checkResp(11'h024, 32'hCAFEF00D, 1'b0);
    checkResp(11'h025, 32'h0, 1'b1);
    checkResp(11'h026, 32'h0, 1'b1);

    $display("[TB] maintenance ops and rd+wr");
    applyStimulus(0, 4'h0, 32'h80000010, 32'h0, 11'h3FF, 0, 0, 1);
    applyStimulus(1, 4'h0, 32'h80000010, 32'h0, 11'h030, 0, 0, 0);
    applyStimulus(1, 4'hF, 32'h80000014, 32'h11112222, 11'h031, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h80000014, 32'h0, 11'h032, 0, 0, 0);
    waitIdle();
    checkResp(11'h3FF, 32'h0, 1'b0);
    checkResp(11'h030, 32'hDEADAAEF, 1'b0);
    checkResp(11'h031, 32'h0, 1'b0);
    checkResp(11'h032, 32'h11112222, 1'b0);

    $display("[TB] reset with a read in flight");
    applyStimulus(1, 4'h0, 32'h80000010, 32'h0, 11'h040, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("dropped_ack", {31'h0, ack_seen[11'h040]}, 32'h0);
    applyStimulus(1, 4'h0, 32'h80000010, 32'h0, 11'h041, 0, 0, 0);
    waitIdle();
    checkResp(11'h041, 32'hDEADAAEF, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 4'hF, 32'h80000200 + 32'(4*i), $urandom, 11'($urandom), 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = 32'h80000200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      t  = 11'($urandom);
      if (op <= 3) begin
        applyStimulus(1, 4'h0, a, 32'h0, t, 0, 0, 0);
      end else if (op <= 6) begin
        w = 4'($urandom_range(1, 15));
        applyStimulus(1'($urandom), w, a, $urandom, t, 0, 0, 0);
      end else if (op == 7) begin
        a = ($urandom_range(0, 1) == 1) ? 32'h80004000 + 32'(4 * $urandom_range(0, 255))
                                        : 32'h7FFFFF00 + 32'(4 * $urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) applyStimulus(1, 4'h0, a, 32'h0, t, 0, 0, 0);
        else                           applyStimulus(0, 4'hF, a, $urandom, t, 0, 0, 0);
      end else if (op == 8) begin
        op = $urandom_range(0, 2);
        applyStimulus(0, 4'h0, a, 32'h0, t, op == 0, op == 1, op == 2);
      end else begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    waitIdle();
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
